// File: rtl/hwag_pkg.sv
// hwag_pkg: shared definitions for the angle-generator blocks.
//   - tpm_state_t   : tooth-period-meter state encoding
//   - TPM_WIDTH_DEF : default width of tooth counts and periods
//   - EDGE_RISE / EDGE_FALL : values of an edge_sel input
package hwag_pkg;

  localparam int TPM_WIDTH_DEF = 24;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } tpm_state_t;

endpackage

// File: rtl/input_edge_sync.sv
// input_edge_sync: three-flop synchroniser for an asynchronous input, plus a
// one-cycle edge pulse whose polarity is chosen by edge_sel.
// Ports:
//   clk        in  clock
//   srst       in  synchronous active-high reset, clears the chain
//   din        in  raw asynchronous input
//   edge_sel   in  EDGE_RISE / EDGE_FALL
//   edge_pulse out high for one cycle per detected edge (from s2/s3)
module input_edge_sync
  import hwag_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic din,
  input  logic edge_sel,
  output logic edge_pulse
);

  logic s1_r;
  logic s2_r;
  logic s3_r;
  logic edge_s;

  // synchroniser chain; runs every clock so edges keep flowing while disabled upstream
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // polarity-selectable edge detect on the settled stages
  always_comb begin
    edge_s = 1'b0;
    if (edge_sel == EDGE_FALL) begin
      edge_s = ~s2_r & s3_r;
    end else begin
      edge_s = s2_r & ~s3_r;
    end
  end

  assign edge_pulse = edge_s;

endmodule

// File: rtl/tooth_period_meter.sv
// tooth_period_meter: measures crank-tooth period in clock cycles and supplies
// the current period and a scaled threshold to the tooth-gap comparator.
// Ports:
//   clk, srst   clock and synchronous active-high reset
//   ena         clock enable for counter, FSM and capture registers
//   cap         raw asynchronous tooth input
//   edge_sel    0 = rising active edge, 1 = falling
//   pcnt_cur    latest period
//   pcnt_prev   previous period
//   pcnt_thr    pcnt_prev + (pcnt_prev >> THR_SHIFT), saturating
//   pcnt_vld    one-cycle pulse when cur/prev/thr are freshly updated together
//   stall       high while rotation is lost
//   run         high while measuring continuously
module tooth_period_meter
  import hwag_pkg::*;
#(
  parameter int               WIDTH     = TPM_WIDTH_DEF,
  parameter logic [WIDTH-1:0] STALL_MAX = {WIDTH{1'b1}},
  parameter int               THR_SHIFT = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             ena,
  input  logic             cap,
  input  logic             edge_sel,
  output logic [WIDTH-1:0] pcnt_cur,
  output logic [WIDTH-1:0] pcnt_prev,
  output logic [WIDTH-1:0] pcnt_thr,
  output logic             pcnt_vld,
  output logic             stall,
  output logic             run
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic             edge_s;
  logic             acc_s;
  tpm_state_t       state_r;
  tpm_state_t       state_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH:0]   inc_s;
  logic [WIDTH-1:0] period_s;
  logic [WIDTH:0]   thr_sum_s;
  logic [WIDTH-1:0] thr_new_s;
  logic [WIDTH-1:0] cur_r, cur_s;
  logic [WIDTH-1:0] prev_r, prev_s;
  logic [WIDTH-1:0] thr_r, thr_s;
  logic             vld_r, vld_s;
  logic             stall_r;
  logic             run_r;

  input_edge_sync u_sync (
    .clk        (clk),
    .srst       (srst),
    .din        (cap),
    .edge_sel   (edge_sel),
    .edge_pulse (edge_s)
  );

  // edges arriving while disabled are dropped, not deferred
  assign acc_s = edge_s & ena;

  // period = cnt + 1, widened so an edge at a saturated all-ones count cannot wrap
  always_comb begin
    inc_s    = {1'b0, cnt_r} + {1'b0, ONE};
    period_s = inc_s[WIDTH] ? ONES : inc_s[WIDTH-1:0];
  end

  // threshold from the value that becomes pcnt_prev (current pcnt_cur)
  always_comb begin
    thr_sum_s = {1'b0, cur_r} + ({1'b0, cur_r} >> THR_SHIFT);
    thr_new_s = thr_sum_s[WIDTH] ? ONES : thr_sum_s[WIDTH-1:0];
  end

  // cycles since last accepted edge, saturating at STALL_MAX
  always_comb begin
    cnt_s = cnt_r;
    if (!ena) begin
      cnt_s = cnt_r;
    end else if (acc_s) begin
      cnt_s = ZERO;
    end else if (cnt_r != STALL_MAX) begin
      cnt_s = cnt_r + ONE;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // next state and capture values; an edge beats a stall timeout in the same cycle
  always_comb begin
    state_s = state_r;
    cur_s   = cur_r;
    prev_s  = prev_r;
    thr_s   = thr_r;
    vld_s   = 1'b0;
    if (ena) begin
      case (state_r)
        IDLE: begin
          if (acc_s) begin
            state_s = ARMED;
          end else begin
            state_s = IDLE;
          end
        end
        ARMED: begin
          if (acc_s) begin
            cur_s   = period_s;
            state_s = RUN;
          end else if (cnt_r == STALL_MAX) begin
            state_s = STALL;
          end else begin
            state_s = ARMED;
          end
        end
        RUN: begin
          if (acc_s) begin
            prev_s = cur_r;
            cur_s  = period_s;
            thr_s  = thr_new_s;
            vld_s  = 1'b1;
          end else if (cnt_r == STALL_MAX) begin
            state_s = STALL;
          end else begin
            state_s = RUN;
          end
        end
        STALL: begin
          if (acc_s) begin
            state_s = ARMED;
          end else begin
            state_s = STALL;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r <= IDLE;
      cnt_r   <= ZERO;
      cur_r   <= ZERO;
      prev_r  <= ZERO;
      thr_r   <= ZERO;
      vld_r   <= 1'b0;
      stall_r <= 1'b0;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cur_r   <= cur_s;
      prev_r  <= prev_s;
      thr_r   <= thr_s;
      vld_r   <= vld_s;
      stall_r <= (state_s == STALL);
      run_r   <= (state_s == RUN);
    end
  end

  assign pcnt_cur  = cur_r;
  assign pcnt_prev = prev_r;
  assign pcnt_thr  = thr_r;
  assign pcnt_vld  = vld_r;
  assign stall     = stall_r;
  assign run       = run_r;

endmodule

// File: tb/tb_tooth_period_meter.sv
// Directed bench for tooth_period_meter: a 24-bit instance with STALL_MAX=500
// and an 8-bit instance for threshold saturation, both fed the same tooth input.
module tb_tooth_period_meter;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        ena = 1'b1;
  logic        cap = 1'b0;
  logic        edge_sel = 1'b0;

  logic [23:0] pcnt_cur, pcnt_prev, pcnt_thr;
  logic        pcnt_vld, stall, run;
  logic [7:0]  cur8, prev8, thr8;
  logic        vld8, stall8, run8;
  logic        agb_r = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int n_vld    = 0;

  logic [31:0] s_cur, s_prev, s_thr, s_cur8, s_prev8, s_thr8;
  logic        s_vld, s_vld_next, s_agb, s_run, s_stall, s_vld8;

  always #5 clk = ~clk;

  tooth_period_meter #(.WIDTH(24), .STALL_MAX(24'd500), .THR_SHIFT(1)) dut (
    .clk(clk), .srst(srst), .ena(ena), .cap(cap), .edge_sel(edge_sel),
    .pcnt_cur(pcnt_cur), .pcnt_prev(pcnt_prev), .pcnt_thr(pcnt_thr),
    .pcnt_vld(pcnt_vld), .stall(stall), .run(run)
  );

  tooth_period_meter #(.WIDTH(8), .STALL_MAX(8'd255), .THR_SHIFT(1)) dut8 (
    .clk(clk), .srst(srst), .ena(ena), .cap(cap), .edge_sel(edge_sel),
    .pcnt_cur(cur8), .pcnt_prev(prev8), .pcnt_thr(thr8),
    .pcnt_vld(vld8), .stall(stall8), .run(run8)
  );

  // downstream comparator model: agb = a > b, one cycle late
  always_ff @(posedge clk) agb_r <= (pcnt_cur > pcnt_thr);

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one tooth: raise cap, snapshot outputs once the edge is captured, and
  // return when the next tooth is due (interval cycles after this rise)
  task automatic tooth(input int interval);
    cap = 1'b1;
    tick(3);
    s_cur   = 32'(pcnt_cur);
    s_prev  = 32'(pcnt_prev);
    s_thr   = 32'(pcnt_thr);
    s_vld   = pcnt_vld;
    s_run   = run;
    s_stall = stall;
    s_cur8  = 32'(cur8);
    s_prev8 = 32'(prev8);
    s_thr8  = 32'(thr8);
    s_vld8  = vld8;
    tick(1);
    s_vld_next = pcnt_vld;
    s_agb      = agb_r;
    tick(6);
    cap = 1'b0;
    tick(interval - 10);
  endtask

  initial begin
    // reset state
    tick(5);
    check("rst_cur", 32'(pcnt_cur), 32'd0);
    check("rst_prev", 32'(pcnt_prev), 32'd0);
    check("rst_thr", 32'(pcnt_thr), 32'd0);
    check("rst_vld", 32'(pcnt_vld), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_thr8", 32'(thr8), 32'd0);
    srst = 1'b0;
    tick(5);

    // start-up: IDLE -> ARMED -> RUN -> first vld on the 3rd edge
    tooth(100);
    check("e1_vld", 32'(s_vld), 32'd0);
    check("e1_run", 32'(s_run), 32'd0);
    tooth(100);
    check("e2_vld", 32'(s_vld), 32'd0);
    check("e2_run", 32'(s_run), 32'd1);
    check("e2_cur", s_cur, 32'd100);
    tooth(100);
    check("e3_vld", 32'(s_vld), 32'd1);
    check("e3_cur", s_cur, 32'd100);
    check("e3_prev", s_prev, 32'd100);
    check("e3_thr", s_thr, 32'd150);
    check("e3_vld_pulse", 32'(s_vld_next), 32'd0);

    // teeth 4..57 at period 100, tooth 58 followed by a 300-cycle gap
    for (int i = 4; i <= 57; i++) begin
      tooth(100);
      n_vld += int'(s_vld);
    end
    check("run_vld_count", 32'(n_vld), 32'd54);
    tooth(300);
    check("e58_agb", 32'(s_agb), 32'd0);
    tooth(100);
    check("gap_cur", s_cur, 32'd300);
    check("gap_prev", s_prev, 32'd100);
    check("gap_thr", s_thr, 32'd150);
    check("gap_vld", 32'(s_vld), 32'd1);
    check("gap_agb", 32'(s_agb), 32'd1);

    // edge after the gap, then no further edges until stall
    cap = 1'b1;
    tick(3);
    check("post_gap_cur", 32'(pcnt_cur), 32'd100);
    check("post_gap_prev", 32'(pcnt_prev), 32'd300);
    check("post_gap_thr", 32'(pcnt_thr), 32'd450);
    check("post_gap_vld", 32'(pcnt_vld), 32'd1);
    tick(7);
    cap = 1'b0;
    tick(493);
    check("stall_500", 32'(stall), 32'd0);
    tick(1);
    check("stall_501", 32'(stall), 32'd1);
    check("stall_run", 32'(run), 32'd0);

    // recovery from STALL: vld only on the 3rd edge, values held meanwhile
    tooth(100);
    check("rec1_vld", 32'(s_vld), 32'd0);
    check("rec1_stall", 32'(s_stall), 32'd0);
    check("rec1_prev_held", s_prev, 32'd300);
    tooth(100);
    check("rec2_vld", 32'(s_vld), 32'd0);
    check("rec2_run", 32'(s_run), 32'd1);
    tooth(100);
    check("rec3_vld", 32'(s_vld), 32'd1);
    check("rec3_prev", s_prev, 32'd100);
    check("rec3_thr", s_thr, 32'd150);

    // edge while ena=0 is dropped; 20 frozen cycles excluded from the span
    tooth(100);
    cap = 1'b1;
    ena = 1'b0;
    tick(3);
    check("ena_drop_vld", 32'(pcnt_vld), 32'd0);
    tick(17);
    ena = 1'b1;
    cap = 1'b0;
    tick(80);
    tooth(100);
    check("ena_cur", s_cur, 32'd180);
    check("ena_prev", s_prev, 32'd100);
    check("ena_vld", 32'(s_vld), 32'd1);

    // srst on the same clock that would accept an edge
    cap = 1'b1;
    tick(2);
    srst = 1'b1;
    cap = 1'b0;
    tick(1);
    check("srst_cur", 32'(pcnt_cur), 32'd0);
    check("srst_prev", 32'(pcnt_prev), 32'd0);
    check("srst_thr", 32'(pcnt_thr), 32'd0);
    check("srst_vld", 32'(pcnt_vld), 32'd0);
    check("srst_run", 32'(run), 32'd0);
    srst = 1'b0;
    tick(20);
    tooth(100);
    check("srst_e1_run", 32'(s_run), 32'd0);
    tooth(100);
    check("srst_e2_vld", 32'(s_vld), 32'd0);
    tooth(100);
    check("srst_e3_vld", 32'(s_vld), 32'd1);

    // 8-bit instance: period 200 -> 200 + 100 saturates to 255
    srst = 1'b1;
    tick(3);
    srst = 1'b0;
    tick(5);
    tooth(200);
    tooth(200);
    tooth(200);
    check("w8_cur", s_cur8, 32'd200);
    check("w8_prev", s_prev8, 32'd200);
    check("w8_thr_sat", s_thr8, 32'd255);
    check("w8_vld", 32'(s_vld8), 32'd1);
    check("w24_thr", s_thr, 32'd300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
